poke_stat_update: RTL and testbench

- Battle-logic stage directly upstream of the per-frame Pokémon stat register.
- Holds one Pokémon's live stats: id, type, level, xp, hp, attack, defense.
- Applies battle events one at a time: damage, heal and XP gain. XP gain includes multi-cycle level-up.
- Presents committed stats on its outputs, which drive the stat register inputs directly.

---
 rtl/poke_pkg.sv | 25 ++
 rtl/poke_levelup_step.sv | 40 ++++
 rtl/poke_stat_update.sv | 231 +++++++++++++++++++++++
 tb/tb_poke_stat_update.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poke_pkg.sv
// Shared types and limits for the Pokemon stat update stage.
// Event kinds, committed stat bundle, and saturation ceilings.
package poke_pkg;

    typedef enum logic [1:0] {
        DAMAGE  = 2'd0,
        HEAL    = 2'd1,
        XP_GAIN = 2'd2,
        RSVD    = 2'd3
    } ev_kind_e;

    typedef struct packed {
        logic [4:0] id;
        logic [2:0] ptype;
        logic [3:0] level;
        logic [7:0] xp;
        logic [5:0] hp;
        logic [3:0] attack;
        logic [3:0] defense;
    } poke_stats_t;

    localparam logic [3:0] STAT_MAX = 4'd15;
    localparam logic [5:0] HP_MAX   = 6'd63;

endpackage

// File: rtl/poke_levelup_step.sv
// Combinational single-level increment of working stats.
// In: level/acc/atk/def/hp/max_hp. Out: same, after one level-up.
module poke_levelup_step
    import poke_pkg::*;
#(
    parameter int XP_PER_LEVEL = 100,
    parameter int HP_GROWTH    = 3
) (
    input  logic [3:0] i_level,
    input  logic [8:0] i_acc,
    input  logic [3:0] i_atk,
    input  logic [3:0] i_def,
    input  logic [5:0] i_hp,
    input  logic [5:0] i_max_hp,
    output logic [3:0] o_level,
    output logic [8:0] o_acc,
    output logic [3:0] o_atk,
    output logic [3:0] o_def,
    output logic [5:0] o_hp,
    output logic [5:0] o_max_hp
);

    logic [6:0] w_max_sum;
    logic [6:0] w_hp_sum;

    assign o_acc   = i_acc - 9'(XP_PER_LEVEL);
    assign o_level = i_level + 4'd1;
    assign o_atk   = (i_atk == STAT_MAX) ? STAT_MAX : i_atk + 4'd1;
    assign o_def   = (i_def == STAT_MAX) ? STAT_MAX : i_def + 4'd1;

    assign w_max_sum = {1'b0, i_max_hp} + 7'(HP_GROWTH);
    assign o_max_hp  = (w_max_sum > {1'b0, HP_MAX}) ?
                       HP_MAX : w_max_sum[5:0];

    // hp grows by the same amount but never past the new ceiling
    assign w_hp_sum = {1'b0, i_hp} + 7'(HP_GROWTH);
    assign o_hp     = (w_hp_sum > {1'b0, o_max_hp}) ?
                      o_max_hp : w_hp_sum[5:0];

endmodule

// File: rtl/poke_stat_update.sv
// Battle event stage: applies damage/heal/xp to working stats and
// commits them to the stat outputs. Ports: load bus, event handshake, stats.
module poke_stat_update
    import poke_pkg::*;
#(
    parameter int XP_PER_LEVEL = 100,
    parameter int HP_GROWTH    = 3,
    parameter int MAX_LEVEL    = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [4:0] ld_poke_id,
    input  logic [2:0] ld_type,
    input  logic [3:0] ld_level,
    input  logic [7:0] ld_xp,
    input  logic [5:0] ld_hp,
    input  logic [3:0] ld_attack,
    input  logic [3:0] ld_defense,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [1:0] ev_kind,
    input  logic [7:0] ev_amount,
    output logic [4:0] poke_id,
    output logic [2:0] type_id,
    output logic [3:0] level,
    output logic [7:0] xp,
    output logic [5:0] hp,
    output logic [3:0] attack,
    output logic [3:0] defense,
    output logic       fainted,
    output logic       upd_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_LVL  = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_nstate;
    poke_stats_t r_o;
    logic        r_done;
    logic        r_loaded;
    ev_kind_e    r_kind;
    logic [7:0]  r_amt;

    logic [4:0]  r_id;
    logic [2:0]  r_type;
    logic [3:0]  r_level;
    logic [8:0]  r_acc;
    logic [5:0]  r_hp;
    logic [5:0]  r_max_hp;
    logic [3:0]  r_atk;
    logic [3:0]  r_def;

    logic [3:0]  n_level;
    logic [8:0]  n_acc;
    logic [5:0]  n_hp;
    logic [5:0]  n_max_hp;
    logic [3:0]  n_atk;
    logic [3:0]  n_def;
    logic        w_commit;

    logic [3:0]  s_level;
    logic [8:0]  s_acc;
    logic [5:0]  s_hp;
    logic [5:0]  s_max_hp;
    logic [3:0]  s_atk;
    logic [3:0]  s_def;

    logic [8:0]  w_sum;
    logic [7:0]  w_dmg;
    logic [5:0]  w_hp_dmg;
    logic [8:0]  w_heal;
    logic        w_noop;
    logic        w_accept;

    poke_levelup_step #(
        .XP_PER_LEVEL(XP_PER_LEVEL),
        .HP_GROWTH   (HP_GROWTH)
    ) u_step (
        .i_level (r_level),
        .i_acc   (r_acc),
        .i_atk   (r_atk),
        .i_def   (r_def),
        .i_hp    (r_hp),
        .i_max_hp(r_max_hp),
        .o_level (s_level),
        .o_acc   (s_acc),
        .o_atk   (s_atk),
        .o_def   (s_def),
        .o_hp    (s_hp),
        .o_max_hp(s_max_hp)
    );

    assign ev_ready = (r_state == S_IDLE) && !load;
    assign w_accept = ev_valid && ev_ready;

    assign w_sum  = r_acc + {1'b0, r_amt};
    assign w_dmg  = (r_amt > {4'd0, r_def}) ?
                    r_amt - {4'd0, r_def} : 8'd1;
    assign w_hp_dmg = ({2'd0, r_hp} > w_dmg) ?
                      r_hp - w_dmg[5:0] : 6'd0;
    assign w_heal = {3'd0, r_hp} + {1'b0, r_amt};
    // fainted or never loaded: consume the event without touching stats
    assign w_noop = !r_loaded || (r_hp == 6'd0);

    always_comb begin
        w_nstate = r_state;
        w_commit = 1'b0;
        n_level  = r_level;
        n_acc    = r_acc;
        n_hp     = r_hp;
        n_max_hp = r_max_hp;
        n_atk    = r_atk;
        n_def    = r_def;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_nstate = S_EXEC;
            end
            S_EXEC: begin
                w_commit = 1'b1;
                if (!w_noop) begin
                    unique case (r_kind)
                        DAMAGE:  n_hp = w_hp_dmg;
                        HEAL:    n_hp = (w_heal > {3'd0, r_max_hp}) ?
                                        r_max_hp : w_heal[5:0];
                        XP_GAIN: begin
                            n_acc = w_sum;
                            if (w_sum >= 9'(XP_PER_LEVEL) &&
                                r_level < 4'(MAX_LEVEL)) begin
                                w_commit = 1'b0;
                                w_nstate = S_LVL;
                            end
                        end
                        RSVD:    ;
                    endcase
                end
            end
            S_LVL: begin
                n_level  = s_level;
                n_acc    = s_acc;
                n_hp     = s_hp;
                n_max_hp = s_max_hp;
                n_atk    = s_atk;
                n_def    = s_def;
                if (!(s_acc >= 9'(XP_PER_LEVEL) &&
                      s_level < 4'(MAX_LEVEL))) begin
                    w_commit = 1'b1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        if (w_commit) begin
            w_nstate = S_IDLE;
            // xp saturates at commit; keeping the accumulator clamped
            // too bounds the next sum to 9 bits
            if (n_acc > 9'd255) n_acc = 9'd255;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else if (load) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_o      <= '0;
            r_done   <= 1'b0;
            r_loaded <= 1'b0;
            r_kind   <= DAMAGE;
            r_amt    <= 8'd0;
            r_id     <= 5'd0;
            r_type   <= 3'd0;
            r_level  <= 4'd0;
            r_acc    <= 9'd0;
            r_hp     <= 6'd0;
            r_max_hp <= 6'd0;
            r_atk    <= 4'd0;
            r_def    <= 4'd0;
        end else if (load) begin
            r_done   <= 1'b1;
            r_loaded <= 1'b1;
            r_id     <= ld_poke_id;
            r_type   <= ld_type;
            r_level  <= ld_level;
            r_acc    <= {1'b0, ld_xp};
            r_hp     <= ld_hp;
            r_max_hp <= ld_hp;
            r_atk    <= ld_attack;
            r_def    <= ld_defense;
            r_o      <= '{ld_poke_id, ld_type, ld_level, ld_xp,
                          ld_hp, ld_attack, ld_defense};
        end else begin
            r_done   <= w_commit;
            r_level  <= n_level;
            r_acc    <= n_acc;
            r_hp     <= n_hp;
            r_max_hp <= n_max_hp;
            r_atk    <= n_atk;
            r_def    <= n_def;
            if (w_accept) begin
                r_kind <= ev_kind_e'(ev_kind);
                r_amt  <= ev_amount;
            end
            if (w_commit) begin
                r_o <= '{r_id, r_type, n_level, n_acc[7:0],
                         n_hp, n_atk, n_def};
            end
        end
    end

    assign poke_id  = r_o.id;
    assign type_id  = r_o.ptype;
    assign level    = r_o.level;
    assign xp       = r_o.xp;
    assign hp       = r_o.hp;
    assign attack   = r_o.attack;
    assign defense  = r_o.defense;
    assign fainted  = r_loaded && (r_o.hp == 6'd0);
    assign upd_done = r_done;

endmodule

// File: tb/tb_poke_stat_update.sv
// Directed bench for poke_stat_update: vector table of loads/events
// plus hand sequences for reset, load abort and load/event collision.
module tb_poke_stat_update;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       load = 1'b0;
    logic [4:0] ld_poke_id = '0;
    logic [2:0] ld_type = '0;
    logic [3:0] ld_level = '0;
    logic [7:0] ld_xp = '0;
    logic [5:0] ld_hp = '0;
    logic [3:0] ld_attack = '0;
    logic [3:0] ld_defense = '0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic [1:0] ev_kind = '0;
    logic [7:0] ev_amount = '0;
    logic [4:0] poke_id;
    logic [2:0] type_id;
    logic [3:0] level;
    logic [7:0] xp;
    logic [5:0] hp;
    logic [3:0] attack;
    logic [3:0] defense;
    logic       fainted;
    logic       upd_done;

    poke_stat_update dut (
        .Clk(Clk), .Reset(Reset), .load(load),
        .ld_poke_id(ld_poke_id), .ld_type(ld_type),
        .ld_level(ld_level), .ld_xp(ld_xp), .ld_hp(ld_hp),
        .ld_attack(ld_attack), .ld_defense(ld_defense),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_kind(ev_kind), .ev_amount(ev_amount),
        .poke_id(poke_id), .type_id(type_id), .level(level),
        .xp(xp), .hp(hp), .attack(attack), .defense(defense),
        .fainted(fainted), .upd_done(upd_done)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    typedef struct {
        bit         ld;
        logic [4:0] id;
        logic [2:0] ty;
        logic [3:0] lv;
        logic [7:0] xpv;
        logic [5:0] hpv;
        logic [3:0] at;
        logic [3:0] df;
        logic [1:0] kind;
        logic [7:0] amt;
        logic [3:0] e_lv;
        logic [7:0] e_xp;
        logic [5:0] e_hp;
        logic [3:0] e_at;
        logic [3:0] e_df;
        bit         e_fn;
        int         e_lat;
    } vec_t;

    function automatic vec_t mkld(int id, int ty, int lv, int x,
                                  int h, int a, int d);
        vec_t v;
        v = '{default: '0};
        v.ld = 1; v.id = 5'(id); v.ty = 3'(ty); v.lv = 4'(lv);
        v.xpv = 8'(x); v.hpv = 6'(h); v.at = 4'(a); v.df = 4'(d);
        v.e_lv = 4'(lv); v.e_xp = 8'(x); v.e_hp = 6'(h);
        v.e_at = 4'(a); v.e_df = 4'(d); v.e_fn = (h == 0);
        v.e_lat = 1;
        return v;
    endfunction

    function automatic vec_t mkev(int k, int amt, int lv, int x, int h,
                                  int a, int d, bit fn, int lat);
        vec_t v;
        v = '{default: '0};
        v.kind = 2'(k); v.amt = 8'(amt);
        v.e_lv = 4'(lv); v.e_xp = 8'(x); v.e_hp = 6'(h);
        v.e_at = 4'(a); v.e_df = 4'(d); v.e_fn = fn; v.e_lat = lat;
        return v;
    endfunction

    logic [4:0] cur_id;
    logic [2:0] cur_ty;

    task automatic do_load(input vec_t v);
        @(negedge Clk);
        load = 1; ld_poke_id = v.id; ld_type = v.ty; ld_level = v.lv;
        ld_xp = v.xpv; ld_hp = v.hpv; ld_attack = v.at;
        ld_defense = v.df;
        cur_id = v.id; cur_ty = v.ty;
        @(posedge Clk); #1;
        load = 0;
        chk("load_done", int'(upd_done), 1);
    endtask

    // returns number of edges from acceptance (inclusive) to commit
    task automatic do_ev(input logic [1:0] k, input logic [7:0] a,
                         output int lat, output bit stable);
        logic [33:0] snap;
        @(negedge Clk);
        chk("ev_ready_idle", int'(ev_ready), 1);
        snap = {poke_id, type_id, level, xp, hp, attack, defense};
        ev_valid = 1; ev_kind = k; ev_amount = a;
        @(posedge Clk); #1;
        ev_valid = 0;
        lat = 1; stable = 1;
        while (!upd_done && lat < 20) begin
            if ({poke_id, type_id, level, xp, hp, attack, defense} !=
                snap || ev_ready) stable = 0;
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, "_id"}, int'(poke_id), int'(cur_id));
        chk({nm, "_type"}, int'(type_id), int'(cur_ty));
        chk({nm, "_level"}, int'(level), int'(v.e_lv));
        chk({nm, "_xp"}, int'(xp), int'(v.e_xp));
        chk({nm, "_hp"}, int'(hp), int'(v.e_hp));
        chk({nm, "_atk"}, int'(attack), int'(v.e_at));
        chk({nm, "_def"}, int'(defense), int'(v.e_df));
        chk({nm, "_fainted"}, int'(fainted), int'(v.e_fn));
    endtask

    vec_t tbl[19];

    initial begin
        int   lat;
        bit   stb;
        int   pulses;
        vec_t v;

        tbl[0]  = mkld(7, 2, 5, 90, 40, 6, 4);
        tbl[1]  = mkev(0, 10, 5, 90, 34, 6, 4, 0, 2);
        tbl[2]  = mkev(0, 3, 5, 90, 33, 6, 4, 0, 2);
        tbl[3]  = mkev(0, 200, 5, 90, 0, 6, 4, 1, 2);
        tbl[4]  = mkev(1, 20, 5, 90, 0, 6, 4, 1, 2);
        tbl[5]  = mkld(7, 2, 5, 90, 40, 6, 4);
        tbl[6]  = mkev(0, 14, 5, 90, 30, 6, 4, 0, 2);
        tbl[7]  = mkev(1, 25, 5, 90, 40, 6, 4, 0, 2);
        tbl[8]  = mkev(2, 250, 8, 40, 49, 9, 7, 0, 5);
        tbl[9]  = mkev(3, 5, 8, 40, 49, 9, 7, 0, 2);
        tbl[10] = mkev(1, 10, 8, 40, 49, 9, 7, 0, 2);
        tbl[11] = mkld(3, 1, 15, 200, 40, 6, 4);
        tbl[12] = mkev(2, 100, 15, 255, 40, 6, 4, 0, 2);
        tbl[13] = mkev(2, 10, 15, 255, 40, 6, 4, 0, 2);
        tbl[14] = mkld(4, 5, 14, 0, 40, 15, 4);
        tbl[15] = mkev(2, 150, 15, 50, 43, 15, 5, 0, 3);
        tbl[16] = mkev(2, 120, 15, 170, 43, 15, 5, 0, 2);
        tbl[17] = mkev(0, 50, 15, 170, 0, 15, 5, 1, 2);
        tbl[18] = mkev(2, 200, 15, 170, 0, 15, 5, 1, 2);

        cur_id = '0; cur_ty = '0;
        #12;
        chk("rst_hp", int'(hp), 0);
        chk("rst_ready", int'(ev_ready), 1);
        chk("rst_done", int'(upd_done), 0);
        @(negedge Clk);
        Reset = 1;

        // event before any load: consumed as a no-op, still commits
        do_ev(2'd2, 8'd150, lat, stb);
        chk("unloaded_lat", lat, 2);
        chk("unloaded_level", int'(level), 0);
        chk("unloaded_xp", int'(xp), 0);
        chk("unloaded_fainted", int'(fainted), 0);

        for (int i = 0; i < 19; i++) begin
            v = tbl[i];
            if (v.ld) begin
                do_load(v);
            end else begin
                do_ev(v.kind, v.amt, lat, stb);
                chk($sformatf("v%0d_lat", i), lat, v.e_lat);
                chk($sformatf("v%0d_stable", i), int'(stb), 1);
            end
            chk_out($sformatf("v%0d", i), v);
        end

        // reset asserted while an xp event is in flight
        v = mkld(7, 2, 5, 90, 40, 6, 4);
        do_load(v);
        @(negedge Clk);
        ev_valid = 1; ev_kind = 2'd2; ev_amount = 8'd250;
        @(posedge Clk); #1;
        ev_valid = 0;
        @(posedge Clk); #3;
        Reset = 0;
        #1;
        chk("midrst_id", int'(poke_id), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_hp", int'(hp), 0);
        chk("midrst_atk", int'(attack), 0);
        chk("midrst_fainted", int'(fainted), 0);
        chk("midrst_ready", int'(ev_ready), 1);
        chk("midrst_done", int'(upd_done), 0);
        @(negedge Clk);
        Reset = 1;

        // load during second LEVEL_UP cycle aborts the xp event
        do_load(v);
        @(negedge Clk);
        ev_valid = 1; ev_kind = 2'd2; ev_amount = 8'd250;
        @(posedge Clk); #1;
        ev_valid = 0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        v = mkld(9, 4, 2, 10, 20, 3, 3);
        load = 1; ld_poke_id = v.id; ld_type = v.ty; ld_level = v.lv;
        ld_xp = v.xpv; ld_hp = v.hpv; ld_attack = v.at;
        ld_defense = v.df;
        cur_id = v.id; cur_ty = v.ty;
        chk("abort_ready_low", int'(ev_ready), 0);
        @(posedge Clk); #1;
        load = 0;
        chk("abort_done", int'(upd_done), 1);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk); #1;
            if (upd_done) pulses++;
        end
        chk("abort_extra_pulses", pulses, 0);
        chk_out("abort", v);
        chk("abort_ready", int'(ev_ready), 1);

        // load with ev_valid high: the event is not taken
        @(negedge Clk);
        v = mkld(1, 1, 3, 20, 30, 5, 5);
        load = 1; ld_poke_id = v.id; ld_type = v.ty; ld_level = v.lv;
        ld_xp = v.xpv; ld_hp = v.hpv; ld_attack = v.at;
        ld_defense = v.df;
        cur_id = v.id; cur_ty = v.ty;
        ev_valid = 1; ev_kind = 2'd0; ev_amount = 8'd30;
        #1;
        chk("collide_ready", int'(ev_ready), 0);
        @(posedge Clk); #1;
        load = 0; ev_valid = 0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            if (upd_done) pulses++;
        end
        chk("collide_pulses", pulses, 0);
        chk_out("collide", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
